// File: rtl/wb_writer.sv
// MEM/WB write-back engine: retires ALU results directly and runs loads through a
// req/ack data-memory read with lane extraction before driving the register-file write port.
module wb_writer #(
  parameter int DMEM_TIMEOUT = 255,
  parameter bit BIG_ENDIAN   = 1'b0
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_reg_write,
  input  logic        ex_mem_to_reg,
  input  logic [2:0]  ex_load_op,
  input  logic [4:0]  ex_reg_dst_id,
  input  logic [31:0] ex_alu_result,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        reg_write_o,
  output logic [4:0]  reg_write_id_o,
  output logic [31:0] reg_write_data_o,
  output logic        wb_stall,
  output logic        misalign_err,
  output logic        timeout_err
);

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;

  // The counter value seen on the last REQ cycle before the abort.
  localparam logic [7:0] LAST_COUNT = 8'(DMEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t      state_reg;
  logic [7:0]  count_reg;
  logic [2:0]  op_reg;
  logic [1:0]  off_reg;
  logic [4:0]  id_reg;

  logic [7:0]  lane_bytes [4];
  logic [2:0]  in_op;
  logic        in_aligned;
  logic        accept;
  logic        count_done;
  logic [31:0] load_data;

  // Unassigned encodings decode as a full-word load.
  function automatic logic [2:0] norm_op(input logic [2:0] op);
    case (op)
      OP_LB, OP_LH, OP_LBU, OP_LHU: norm_op = op;
      default:                      norm_op = OP_LW;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [2:0] op, input logic [1:0] off);
    case (op)
      OP_LH, OP_LHU: is_aligned = ~off[0];
      OP_LW:         is_aligned = (off == 2'b00);
      default:       is_aligned = 1'b1;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_bytes[gi] = dmem_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    logic [1:0]  lane;
    logic [7:0]  b;
    logic [15:0] h;
    lane = BIG_ENDIAN ? ~off_reg : off_reg;
    b    = lane_bytes[lane];
    h    = (off_reg[1] ^ BIG_ENDIAN) ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (op_reg)
      OP_LB:   load_data = {{24{b[7]}}, b};
      OP_LBU:  load_data = {24'd0, b};
      OP_LH:   load_data = {{16{h[15]}}, h};
      OP_LHU:  load_data = {16'd0, h};
      default: load_data = dmem_rdata;
    endcase
  end

  assign in_op      = norm_op(ex_load_op);
  assign in_aligned = is_aligned(in_op, ex_alu_result[1:0]);
  assign accept     = ex_valid & ex_ready;
  assign count_done = (count_reg == LAST_COUNT);
  assign wb_stall   = ~ex_ready;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      ex_ready         <= 1'b1;
      dmem_req         <= 1'b0;
      dmem_addr        <= '0;
      reg_write_o      <= 1'b0;
      reg_write_id_o   <= '0;
      reg_write_data_o <= '0;
      misalign_err     <= 1'b0;
      timeout_err      <= 1'b0;
      count_reg        <= '0;
      op_reg           <= OP_LW;
      off_reg          <= '0;
      id_reg           <= '0;
    end else begin
      reg_write_o  <= 1'b0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
      case (state_reg)
        IDLE, WRITE: begin
          state_reg <= IDLE;
          ex_ready  <= 1'b1;
          if (accept) begin
            if (!ex_mem_to_reg) begin
              state_reg <= WRITE;
              // Register 0 is never written; id/data hold their last value when no pulse.
              if (ex_reg_write && (ex_reg_dst_id != 5'd0)) begin
                reg_write_o      <= 1'b1;
                reg_write_id_o   <= ex_reg_dst_id;
                reg_write_data_o <= ex_alu_result;
              end
            end else if (!in_aligned) begin
              misalign_err <= 1'b1;
            end else begin
              state_reg <= REQ;
              ex_ready  <= 1'b0;
              dmem_req  <= 1'b1;
              dmem_addr <= {ex_alu_result[31:2], 2'b00};
              count_reg <= '0;
              op_reg    <= in_op;
              off_reg   <= ex_alu_result[1:0];
              id_reg    <= ex_reg_dst_id;
            end
          end
        end
        REQ: begin
          if (dmem_ack) begin
            state_reg <= WRITE;
            ex_ready  <= 1'b1;
            dmem_req  <= 1'b0;
            if (id_reg != 5'd0) begin
              reg_write_o      <= 1'b1;
              reg_write_id_o   <= id_reg;
              reg_write_data_o <= load_data;
            end
          end else if (count_done) begin
            state_reg   <= IDLE;
            ex_ready    <= 1'b1;
            dmem_req    <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            count_reg <= count_reg + 8'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          ex_ready  <= 1'b1;
          dmem_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer: little- and big-endian instances share stimulus; a per-cycle
// expectation timeline built from transaction-level rules is compared every cycle.
module tb_wb_writer;

  localparam int T_OUT = 4;
  localparam int MAXW  = 512;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_reg_write, ex_mem_to_reg;
  logic [2:0]  ex_load_op;
  logic [4:0]  ex_reg_dst_id;
  logic [31:0] ex_alu_result;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  logic        le_ready, le_req, le_write, le_stall, le_mis, le_to;
  logic [31:0] le_addr, le_data;
  logic [4:0]  le_id;
  logic        be_ready, be_req, be_write, be_stall, be_mis, be_to;
  logic [31:0] be_addr, be_data;
  logic [4:0]  be_id;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  logic        exp_ready [MAXW];
  logic        exp_req   [MAXW];
  logic        exp_write [MAXW];
  logic        exp_mis   [MAXW];
  logic        exp_to    [MAXW];
  logic [31:0] exp_addr  [MAXW];
  logic [4:0]  exp_id    [MAXW];
  logic [31:0] exp_data  [MAXW];
  logic [31:0] exp_dbe   [MAXW];

  wb_writer #(.DMEM_TIMEOUT(T_OUT), .BIG_ENDIAN(1'b0)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(le_ready),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_load_op(ex_load_op),
    .ex_reg_dst_id(ex_reg_dst_id), .ex_alu_result(ex_alu_result), .dmem_req(le_req),
    .dmem_addr(le_addr), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .reg_write_o(le_write),
    .reg_write_id_o(le_id), .reg_write_data_o(le_data), .wb_stall(le_stall),
    .misalign_err(le_mis), .timeout_err(le_to)
  );

  wb_writer #(.DMEM_TIMEOUT(T_OUT), .BIG_ENDIAN(1'b1)) dut_be (
    .sys_clk(sys_clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(be_ready),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_load_op(ex_load_op),
    .ex_reg_dst_id(ex_reg_dst_id), .ex_alu_result(ex_alu_result), .dmem_req(be_req),
    .dmem_addr(be_addr), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .reg_write_o(be_write),
    .reg_write_id_o(be_id), .reg_write_data_o(be_data), .wb_stall(be_stall),
    .misalign_err(be_mis), .timeout_err(be_to)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Reference extraction: shift the word so the wanted lane lands at bit 0.
  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] w, input bit be);
    int sh;
    logic [31:0] v;
    case (op)
      3'b000, 3'b100: begin
        sh = be ? 8 * (3 - int'(addr[1:0])) : 8 * int'(addr[1:0]);
        v  = (w >> sh) & 32'h0000_00FF;
        if (op == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
      end
      3'b001, 3'b101: begin
        sh = (addr[1] != be) ? 16 : 0;
        v  = (w >> sh) & 32'h0000_FFFF;
        if (op == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic bit model_aligned(input logic [2:0] op, input logic [31:0] addr);
    case (op)
      3'b000, 3'b100: return 1'b1;
      3'b001, 3'b101: return addr[0] == 1'b0;
      default:        return addr[1:0] == 2'b00;
    endcase
  endfunction

  task automatic sched_write(input int w, input logic [4:0] id, input logic [31:0] d,
                             input logic [31:0] dbe);
    if (id != 5'd0) begin
      exp_write[w] = 1'b1;
      exp_id[w]    = id;
      exp_data[w]  = d;
      exp_dbe[w]   = dbe;
    end
  endtask

  task automatic sched_req(input int from, input int upto, input logic [31:0] addr);
    for (int w = from; w <= upto; w++) begin
      exp_req[w]   = 1'b1;
      exp_ready[w] = 1'b0;
      exp_addr[w]  = {addr[31:2], 2'b00};
    end
  endtask

  task automatic check_dut(input string tag, input int w, input logic rdy, input logic stall,
                           input logic req, input logic [31:0] addr, input logic wr,
                           input logic [4:0] id, input logic [31:0] data, input logic mis,
                           input logic to, input logic [31:0] exp_d);
    chk({tag, ".ex_ready"}, {31'd0, rdy}, {31'd0, exp_ready[w]});
    chk({tag, ".wb_stall"}, {31'd0, stall}, {31'd0, ~exp_ready[w]});
    chk({tag, ".dmem_req"}, {31'd0, req}, {31'd0, exp_req[w]});
    chk({tag, ".reg_write"}, {31'd0, wr}, {31'd0, exp_write[w]});
    chk({tag, ".misalign"}, {31'd0, mis}, {31'd0, exp_mis[w]});
    chk({tag, ".timeout"}, {31'd0, to}, {31'd0, exp_to[w]});
    if (exp_req[w]) chk({tag, ".dmem_addr"}, addr, exp_addr[w]);
    if (exp_write[w]) begin
      chk({tag, ".wr_id"}, {27'd0, id}, {27'd0, exp_id[w]});
      chk({tag, ".wr_data"}, data, exp_d);
    end
  endtask

  always @(negedge sys_clk) begin
    if (cyc >= 1 && cyc < MAXW) begin
      check_dut("le", cyc, le_ready, le_stall, le_req, le_addr, le_write, le_id, le_data,
                le_mis, le_to, exp_data[cyc]);
      check_dut("be", cyc, be_ready, be_stall, be_req, be_addr, be_write, be_id, be_data,
                be_mis, be_to, exp_dbe[cyc]);
      $display("cyc=%0d le_wr=%b id=%0d data=%h req=%b rdy=%b mis=%b to=%b be_data=%h",
               cyc, le_write, le_id, le_data, le_req, le_ready, le_mis, le_to, be_data);
    end
  end

  // Leaves ex_valid high so a following call lands back-to-back.
  task automatic alu(input logic [4:0] id, input logic [31:0] d, input logic wr);
    int n;
    @(negedge sys_clk);
    n = cyc;
    ex_valid = 1'b1; ex_mem_to_reg = 1'b0; ex_reg_write = wr;
    ex_reg_dst_id = id; ex_alu_result = d; ex_load_op = 3'b000;
    if (wr) sched_write(n + 1, id, d, d);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge sys_clk);
      ex_valid = 1'b0;
    end
  endtask

  // d = cycles from accept to ack (1..T_OUT); d = 0 means no ack until after the abort.
  task automatic load(input logic [2:0] op, input logic [31:0] addr, input logic [4:0] id,
                      input int d, input logic [31:0] rdata, input bit pin,
                      input logic [31:0] lit, input logic [31:0] lit_be);
    int n;
    int m;
    logic [2:0] eop;
    @(negedge sys_clk);
    n = cyc;
    ex_valid = 1'b1; ex_mem_to_reg = 1'b1; ex_reg_write = 1'b1;
    ex_reg_dst_id = id; ex_alu_result = addr; ex_load_op = op;
    eop = (op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b101) ? op : 3'b011;
    if (!model_aligned(eop, addr)) begin
      exp_mis[n + 1] = 1'b1;
      @(negedge sys_clk);
      ex_valid = 1'b0;
      if (pin) begin
        chk("pin.misalign_pulse", {31'd0, le_mis}, 32'd1);
        chk("pin.misalign_noreq", {31'd0, le_req}, 32'd0);
        chk("pin.misalign_ready", {31'd0, le_ready}, 32'd1);
      end
      return;
    end
    if (d == 0) begin
      sched_req(n + 1, n + T_OUT, addr);
      exp_to[n + T_OUT + 1] = 1'b1;
      @(negedge sys_clk);
      ex_valid = 1'b0;
      while (cyc < n + T_OUT) @(negedge sys_clk);
      if (pin) chk("pin.req_last", {31'd0, le_req}, 32'd1);
      @(negedge sys_clk);
      if (pin) begin
        chk("pin.timeout_pulse", {31'd0, le_to}, 32'd1);
        chk("pin.timeout_req_low", {31'd0, le_req}, 32'd0);
      end
      @(negedge sys_clk);
      dmem_ack = 1'b1; dmem_rdata = rdata;
      @(negedge sys_clk);
      dmem_ack = 1'b0;
      return;
    end
    m = n + d;
    sched_req(n + 1, m, addr);
    sched_write(m + 1, id, model_load(eop, addr, rdata, 1'b0), model_load(eop, addr, rdata, 1'b1));
    @(negedge sys_clk);
    ex_valid = 1'b0;
    while (cyc < m) @(negedge sys_clk);
    dmem_ack = 1'b1; dmem_rdata = rdata;
    @(negedge sys_clk);
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    if (pin) begin
      chk("pin.load_le", le_data, lit);
      chk("pin.load_be", be_data, lit_be);
    end
  endtask

  initial begin
    int n;
    for (int w = 0; w < MAXW; w++) begin
      exp_ready[w] = 1'b1; exp_req[w] = 1'b0; exp_write[w] = 1'b0;
      exp_mis[w] = 1'b0;   exp_to[w] = 1'b0;  exp_addr[w] = '0;
      exp_id[w] = '0;      exp_data[w] = '0;  exp_dbe[w] = '0;
    end
    rst_n = 1'b0; ex_valid = 1'b0; ex_reg_write = 1'b0; ex_mem_to_reg = 1'b0;
    ex_load_op = 3'b000; ex_reg_dst_id = '0; ex_alu_result = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (3) @(negedge sys_clk);
    chk("pin.reset_ready", {31'd0, le_ready}, 32'd1);
    chk("pin.reset_req", {31'd0, le_req}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    alu(5'd5, 32'h1234_5678, 1'b1);
    @(negedge sys_clk);
    ex_valid = 1'b0;
    chk("pin.addu_write", {31'd0, le_write}, 32'd1);
    chk("pin.addu_data", le_data, 32'h1234_5678);
    @(negedge sys_clk);
    chk("pin.addu_gap", {31'd0, le_write}, 32'd0);

    load(3'b000, 32'h1003, 5'd6, 2, 32'h80FF_0011, 1, 32'hFFFF_FF80, 32'h0000_0011);
    load(3'b100, 32'h1003, 5'd7, 2, 32'h80FF_0011, 1, 32'h0000_0080, 32'h0000_0011);
    load(3'b001, 32'h1002, 5'd8, 2, 32'hBEEF_1234, 1, 32'hFFFF_BEEF, 32'h0000_1234);
    load(3'b101, 32'h1002, 5'd9, 2, 32'hBEEF_1234, 1, 32'h0000_BEEF, 32'h0000_1234);
    load(3'b001, 32'h1000, 5'd10, 1, 32'h7FFF_8001, 1, 32'hFFFF_8001, 32'h0000_7FFF);
    load(3'b000, 32'h1001, 5'd11, 3, 32'h1122_3344, 1, 32'h0000_0033, 32'h0000_0022);
    load(3'b011, 32'h2000, 5'd12, 1, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 32'hCAFE_F00D);
    load(3'b110, 32'h3004, 5'd13, T_OUT, 32'h0BAD_BEEF, 1, 32'h0BAD_BEEF, 32'h0BAD_BEEF);
    load(3'b011, 32'h1001, 5'd14, 1, 32'h0, 1, 32'h0, 32'h0);
    load(3'b001, 32'h1001, 5'd14, 1, 32'h0, 1, 32'h0, 32'h0);
    load(3'b101, 32'h1003, 5'd14, 1, 32'h0, 0, 32'h0, 32'h0);
    load(3'b011, 32'h1002, 5'd14, 1, 32'h0, 0, 32'h0, 32'h0);
    load(3'b011, 32'h2000, 5'd0, 2, 32'h5555_AAAA, 0, 32'h0, 32'h0);
    idle(1);
    alu(5'd7, 32'hDEAD_0000, 1'b0);
    alu(5'd0, 32'h0000_BEEF, 1'b1);
    idle(2);
    load(3'b011, 32'h4000, 5'd15, 0, 32'h1111_1111, 1, 32'h0, 32'h0);
    idle(2);

    alu(5'd1, 32'hA5A5_0001, 1'b1);
    alu(5'd2, 32'hA5A5_0002, 1'b1);
    load(3'b100, 32'h1003, 5'd3, 1, 32'h80FF_0011, 1, 32'h0000_0080, 32'h0000_0011);
    alu(5'd4, 32'hA5A5_0004, 1'b1);
    idle(2);

    // Reset asserted while a load is outstanding; the late ack must be ignored.
    @(negedge sys_clk);
    n = cyc;
    ex_valid = 1'b1; ex_mem_to_reg = 1'b1; ex_reg_write = 1'b1;
    ex_reg_dst_id = 5'd20; ex_alu_result = 32'h1000; ex_load_op = 3'b011;
    sched_req(n + 1, n + 2, 32'h1000);
    @(negedge sys_clk);
    ex_valid = 1'b0;
    @(negedge sys_clk);
    rst_n = 1'b0;
    @(negedge sys_clk);
    rst_n = 1'b1;
    chk("pin.rst_req_drop", {31'd0, le_req}, 32'd0);
    chk("pin.rst_stall_drop", {31'd0, le_stall}, 32'd0);
    @(negedge sys_clk);
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge sys_clk);
    dmem_ack = 1'b0;
    chk("pin.stray_ack_nowrite", {31'd0, le_write}, 32'd0);
    alu(5'd21, 32'h0000_0021, 1'b1);
    alu(5'd22, 32'h0000_0022, 1'b1);
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

endmodule
